// File: rtl/lc3b_mem_responder_pkg.sv
// Shared types for the LC-3b memory responder.
//   lc3b_types             : bus word and byte-mask types used on every port.
//   lc3b_mem_responder_pkg : responder-internal constants and the latched
//                            operation encoding.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
endpackage

package lc3b_mem_responder_pkg;
    import lc3b_types::*;

    // The counter only has to hold LATENCY-1, and LATENCY is at most 15.
    localparam int CNT_W = 4;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // A request with mem_write set executes as a write, even if mem_read
    // is also set.
    function automatic op_e decode_op(input logic mem_write);
        return mem_write ? OP_WRITE : OP_READ;
    endfunction
endpackage

// File: rtl/lc3b_mem_responder_if.sv
// Request/response bus between an LC-3b initiator and the memory responder.
//   master : drives mem_read, mem_write, mem_address, mem_wdata,
//            mem_byte_enable; receives mem_resp, mem_rdata, mem_error.
//   slave  : the responder side, with the directions reversed.
interface lc3b_mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    logic          mem_resp;
    lc3b_word      mem_rdata;
    logic          mem_error;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata, mem_error
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata, mem_error
    );
endinterface

// File: rtl/lc3b_mem_responder_byte_ram.sv
// lc3b_byte_ram: 2^ADDR_BITS x 16-bit storage with per-byte write mask
// and a registered read port.
//   clk, reset : clock; synchronous active-high reset (read register only)
//   we_i       : write enable; wmask_i selects the bytes taken from wdata_i
//   re_i       : read enable; the read register updates only on re_i
//   addr_i     : word index shared by the read and write paths
//   rdata_o    : registered read data, held until the next read
module lc3b_byte_ram
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  lc3b_mem_wmask        wmask_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  lc3b_word             wdata_i,
    output lc3b_word             rdata_o
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [1:0][7:0] mem_q [DEPTH];
    lc3b_word        rdata_q;

    // NOTE: the array has no reset branch, so it maps onto a plain RAM
    // macro and keeps its contents across a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (wmask_i[0]) mem_q[addr_i][0] <= wdata_i[7:0];
            if (wmask_i[1]) mem_q[addr_i][1] <= wdata_i[15:8];
        end
    end

    // The read register only moves on a read, so writes never disturb the
    // last returned word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: fixed-latency memory model for an LC-3b datapath.
// A request seen in IDLE is latched and answered with a one-cycle mem_resp
// exactly LATENCY cycles later; writes commit and reads are captured on the
// edge that raises mem_resp.
//   clk, reset : clock; synchronous active-high reset
//   bus        : slave side of lc3b_mem_responder_if
// Parameters:
//   LATENCY        : acceptance-to-response distance in cycles, 1..15
//   WORD_ADDR_BITS : log2 of the word depth; the address wraps above it
module lc3b_mem_responder
    import lc3b_types::*;
    import lc3b_mem_responder_pkg::*;
#(
    parameter int LATENCY        = 3,
    parameter int WORD_ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3b_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef logic [WORD_ADDR_BITS-1:0] idx_t;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    op_e                op_q;
    logic               conflict_q;
    idx_t               idx_q;
    lc3b_word           wdata_q;
    lc3b_mem_wmask      wmask_q;
    logic               resp_q;
    logic               error_q;

    logic               accept;
    logic               enter_resp;
    op_e                cur_op;
    logic               cur_conflict;
    idx_t               cur_idx;
    lc3b_word           cur_wdata;
    lc3b_mem_wmask      cur_wmask;
    lc3b_word           ram_rdata;
    logic               unused_addr;

    // With LATENCY=1 the RESP entry edge is the acceptance edge itself, so
    // the RAM has to see the live bus instead of the (not yet loaded) latches.
    // NOTE: every signal written here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        accept       = (state_q == S_IDLE) && (bus.mem_read || bus.mem_write);
        enter_resp   = !reset &&
                       ((accept && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == CNT_W'(1))));
        cur_op       = op_q;
        cur_conflict = conflict_q;
        cur_idx      = idx_q;
        cur_wdata    = wdata_q;
        cur_wmask    = wmask_q;
        if (accept) begin
            cur_op       = decode_op(bus.mem_write);
            cur_conflict = bus.mem_read && bus.mem_write;
            cur_idx      = bus.mem_address[WORD_ADDR_BITS:1];
            cur_wdata    = bus.mem_wdata;
            cur_wmask    = bus.mem_byte_enable;
        end
    end

    // Bit 0 and the bits above the array depth are intentionally dropped.
    assign unused_addr = ^bus.mem_address;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_READ;
            conflict_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            resp_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            resp_q  <= enter_resp;
            error_q <= enter_resp && cur_conflict;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= cur_op;
                        conflict_q <= cur_conflict;
                        idx_q      <= cur_idx;
                        wdata_q    <= cur_wdata;
                        wmask_q    <= cur_wmask;
                        if (LATENCY == 1) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    lc3b_byte_ram #(
        .ADDR_BITS (WORD_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (enter_resp && (cur_op == OP_WRITE)),
        .wmask_i (cur_wmask),
        .re_i    (enter_resp && (cur_op == OP_READ)),
        .addr_i  (cur_idx),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.mem_resp  = resp_q;
    assign bus.mem_error = error_q;
    assign bus.mem_rdata = ram_rdata;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Testbench for lc3b_mem_responder. Two instances run side by side: index 0
// uses LATENCY=3, index 1 uses LATENCY=1; both use 256-word arrays.
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic reset;

    logic          rd    [2];
    logic          wr    [2];
    lc3b_word      addr  [2];
    lc3b_word      wdata [2];
    lc3b_mem_wmask be    [2];
    logic          resp  [2];
    logic          err   [2];
    lc3b_word      rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference contents of each array and the last word each one returned.
    lc3b_word mdl [2][256];
    lc3b_word last_rd [2];

    always #5 clk = ~clk;

    lc3b_mem_responder_if bus0 ();
    lc3b_mem_responder_if bus1 ();

    assign bus0.mem_read        = rd[0];
    assign bus0.mem_write       = wr[0];
    assign bus0.mem_address     = addr[0];
    assign bus0.mem_wdata       = wdata[0];
    assign bus0.mem_byte_enable = be[0];
    assign resp[0]              = bus0.mem_resp;
    assign err[0]               = bus0.mem_error;
    assign rdata[0]             = bus0.mem_rdata;

    assign bus1.mem_read        = rd[1];
    assign bus1.mem_write       = wr[1];
    assign bus1.mem_address     = addr[1];
    assign bus1.mem_wdata       = wdata[1];
    assign bus1.mem_byte_enable = be[1];
    assign resp[1]              = bus1.mem_resp;
    assign err[1]               = bus1.mem_error;
    assign rdata[1]             = bus1.mem_rdata;

    lc3b_mem_responder #(.LATENCY(LAT0), .WORD_ADDR_BITS(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    lc3b_mem_responder #(.LATENCY(LAT1), .WORD_ADDR_BITS(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction on instance s, starting #1 after a rising edge.
    // from_resp: the instance is currently in its response cycle, so the
    //            request is presented there and must not be taken until the
    //            following cycle.
    // hold     : leave the request on the bus after the response cycle.
    // scramble : randomise the bus right after acceptance.
    task automatic txn(input int s, input logic r, input logic w,
                       input lc3b_word a, input lc3b_word d, input lc3b_mem_wmask m,
                       input bit scramble, input bit hold, input bit from_resp);
        int       lat;
        int       idx;
        lc3b_word exp_rd;
        lat = (s == 0) ? LAT0 : LAT1;
        idx = (int'(a) / 2) % 256;
        if (w) begin
            if (m[0]) mdl[s][idx][7:0]  = d[7:0];
            if (m[1]) mdl[s][idx][15:8] = d[15:8];
        end else begin
            last_rd[s] = mdl[s][idx];
        end
        exp_rd = last_rd[s];

        rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d; be[s] = m;
        if (from_resp) begin
            @(posedge clk); #1;
            check("gap_resp", 32'(resp[s]), 32'd0);
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1 && scramble) begin
                rd[s]    = 1'($urandom_range(1));
                wr[s]    = 1'($urandom_range(1));
                addr[s]  = 16'($urandom);
                wdata[s] = 16'($urandom);
                be[s]    = 2'($urandom);
            end
            check("resp_timing", 32'(resp[s]), 32'(k == lat));
        end
        check("error", 32'(err[s]), 32'(r & w));
        check("rdata", 32'(rdata[s]), 32'(exp_rd));
        if (!hold) begin
            rd[s] = 1'b0; wr[s] = 1'b0;
            @(posedge clk); #1;
            check("resp_pulse_end", 32'(resp[s]), 32'd0);
            check("error_pulse_end", 32'(err[s]), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int s = 0; s < 2; s++) begin
            check({tag, "_resp"}, 32'(resp[s]), 32'd0);
            check({tag, "_error"}, 32'(err[s]), 32'd0);
            check({tag, "_rdata"}, 32'(rdata[s]), 32'd0);
            last_rd[s] = 16'h0000;
        end
    endtask

    // Accept a write on instance 0, then pull reset during cycle at_cycle.
    task automatic abort_write(input lc3b_word a, input int at_cycle);
        bit seen;
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = a; wdata[0] = 16'hFFFF; be[0] = 2'b11;
        @(posedge clk); #1;
        for (int c = 1; c < at_cycle; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        wr[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("abort_reset");
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (resp[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0; be[s] = '0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("reset");

        // Give every word a known value.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                txn(s, 1'b0, 1'b1, 16'(i * 2), 16'($urandom), 2'b11, 1'b0, 1'b0, 1'b0);
            end
        end

        // Read with LATENCY=3.
        txn(0, 1'b0, 1'b1, 16'h0008, 16'hBEEF, 2'b11, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b1, 1'b0, 16'h0008, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        check("read_beef", 32'(rdata[0]), 32'h0000_BEEF);

        // Byte writes and an empty mask, on both latencies.
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0, 1'b0, 1'b0);
            txn(s, 1'b0, 1'b1, 16'h0010, 16'hABCD, 2'b10, 1'b0, 1'b0, 1'b0);
            txn(s, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
            check("byte_hi", 32'(rdata[s]), 32'h0000_AB34);
            txn(s, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0, 1'b0, 1'b0);
            txn(s, 1'b0, 1'b1, 16'h0010, 16'hABCD, 2'b01, 1'b0, 1'b0, 1'b0);
            txn(s, 1'b1, 1'b0, 16'h0011, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0);
            check("byte_lo", 32'(rdata[s]), 32'h0000_12CD);
            txn(s, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, 1'b0, 1'b0, 1'b0);
            txn(s, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0);
            check("mask_none", 32'(rdata[s]), 32'h0000_12CD);
        end

        // LATENCY=1 back-to-back: read held straight after the write response.
        txn(1, 1'b0, 1'b1, 16'h0002, 16'h5A5A, 2'b11, 1'b0, 1'b1, 1'b0);
        txn(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
        check("b2b_read", 32'(rdata[1]), 32'h0000_5A5A);

        // Conflicting request with an aliased address.
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b1, 1'b1, 16'h0206, 16'h0F0F, 2'b11, 1'b0, 1'b0, 1'b0);
            txn(s, 1'b1, 1'b0, 16'h0006, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
            check("alias_read", 32'(rdata[s]), 32'h0000_0F0F);
        end

        // Reset during WAIT, and on the edge that would enter RESP.
        abort_write(16'h0020, 1);
        txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
        abort_write(16'h0030, 2);
        txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Random traffic, including bus changes after acceptance.
        for (int n = 0; n < 120; n++) begin
            int          s;
            int          pick;
            logic        r;
            logic        w;
            s    = n % 2;
            pick = int'($urandom_range(9));
            r    = (pick <= 4);
            w    = (pick == 0) || (pick >= 5);
            txn(s, r, w, 16'($urandom), 16'($urandom), 2'($urandom),
                1'($urandom_range(1)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
